nios_pio_in_edge: RTL
=====================

Name: nios_pio_in_edge

Overview:
- Parametrised Avalon-MM input PIO slave for the Nios system; next generation of the single-bit switch port.
- Samples a WIDTH-bit asynchronous input bus (switches, keys) and passes it through a 2-flop synchroniser and an optional per-bit debouncer.
- Captures configurable edges into a sticky register and raises a maskable level interrupt to the CPU.

Parameters:
- WIDTH, 8, number of input bits (1..32).
- EDGE_TYPE, 0, edge that sets capture bits: 0 = rising, 1 = falling, 2 = any.
- DEBOUNCE_CYCLES, 0, consecutive stable cycles needed before the debounced value changes; 0 = debounce bypassed.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset; asynchronous assert, active-low.
- address  in  2  Avalon register word address.
- chipselect  in  1  Avalon slave select.
- write_n  in  1  Avalon write strobe, active-low.
- writedata  in  32  Avalon write data.
- in_port  in  WIDTH  asynchronous external inputs.
- readdata  out  32  registered read data.
- irq  out  1  level interrupt to CPU.

Behaviour:
- Reset (reset_n = 0, asynchronous): sync flops, debounced value, previous value, debounce counters, irq_mask, edge_capture and readdata all 0. irq = 0.
- Reset mid-operation: all state clears immediately, including pending captures and counters. The first edge-detect cycle after release compares against prev = 0.
- Register map:
  - addr 0: data, RO, debounced value in bits [WIDTH-1:0].
  - addr 1: reserved, reads 0, writes ignored.
  - addr 2: irq_mask, RW, bits [WIDTH-1:0].
  - addr 3: edge_capture, read; write-1-to-clear per bit.
  - Bits 31:WIDTH always read 0.
- Write: occurs when chipselect = 1 and write_n = 0 on a clk edge.
  - addr 2 loads irq_mask from writedata[WIDTH-1:0].
  - addr 3 clears each edge_capture bit whose writedata bit = 1.
- Read: readdata is registered every clk edge from the address mux, independent of chipselect. Read latency is 1 cycle.
- Synchroniser: sync1 <= in_port, then sync2 <= sync1.
- Debounce, DEBOUNCE_CYCLES = 0: stable = sync2.
- Debounce, DEBOUNCE_CYCLES = N > 0, per bit:
  - Counter of width clog2(N+1).
  - If sync2 == stable, counter <= 0.
  - Else, if counter == N-1: stable <= sync2, counter <= 0.
  - Else counter <= counter+1.
  - A mismatch lasting fewer than N cycles never changes stable. A mismatch lasting N cycles changes stable on the Nth edge.
- Edge detect: prev <= stable every cycle.
  - rise = stable & ~prev; fall = ~stable & prev.
  - Selected by EDGE_TYPE; any = rise | fall.
- edge_capture bit update: next = (cur & ~clear) | edge. A simultaneous set and clear on the same bit leaves the bit set (set wins).
- irq = |(edge_capture & irq_mask), combinational from registers only. There is no combinational path from in_port or the bus to irq.
- Latency with N = 0, in_port change to visibility:
  - stable changes 2 edges after the in_port change.
  - edge_capture sets on edge 3.
  - addr-0 readdata reflects the change on edge 3.
- Latency with N > 0: add N edges to each of the above.
- Inputs wider than WIDTH do not exist; writedata bits above WIDTH-1 are ignored.

Test Plan:
- Reset, WIDTH = 8: hold reset_n = 0, in_port = 8'hFF → readdata = 0, irq = 0. After release, addr 0 reads 32'h000000FF once the synchroniser has filled (3 edges), upper 24 bits 0.
- Rising capture, EDGE_TYPE = 0, N = 0: irq_mask = 8'h01; in_port bit0 goes 0→1 → edge_capture = 8'h01 on edge 3, irq = 1. Bit0 1→0 adds no capture bit.
- W1C and collision: edge_capture = 8'h03; write 32'h1 to addr 3 → edge_capture = 8'h02, irq = 0 with mask 8'h01. Write 32'h2 in the same cycle bit1 edges again → bit1 stays 1.
- Debounce N = 4: 3-cycle glitch on bit2 → data and edge_capture unchanged. 4-cycle pulse → data bit2 = 1 exactly 2+4 edges after the input change, capture set one edge later.
- EDGE_TYPE = 2: a toggle 0→1→0 on bit5, with capture cleared between the two transitions → capture set by each transition. With EDGE_TYPE = 1, only the 1→0 transition sets the bit.
- Reset mid-operation: set edge_capture = 8'hF0 and mask = 8'hF0 (irq = 1); pulse reset_n low for 1 cycle → edge_capture = 0, mask = 0, irq = 0 asynchronously. Debounce counters restart from 0.

Source files
------------

// File: rtl/nios_pio_in_edge.sv
// Avalon-MM input PIO: synchronised, optionally debounced inputs with sticky
// edge capture and a maskable level interrupt.
module nios_pio_in_edge #(
    parameter int WIDTH           = 8,
    parameter int EDGE_TYPE       = 0,
    parameter int DEBOUNCE_CYCLES = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;
    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] edge_hit;
    logic [WIDTH-1:0] cap_clear;
    logic [WIDTH-1:0] edge_capture_q;
    logic [WIDTH-1:0] edge_capture_d;
    logic [WIDTH-1:0] irq_mask_q;
    logic [WIDTH-1:0] irq_mask_d;
    logic [31:0]      readdata_q;
    logic [31:0]      readdata_d;
    logic             wr_en;

    assign wr_en = chipselect & ~write_n;

    generate
        if (WIDTH < 32) begin : g_unused_wd
            logic unused_writedata;
            assign unused_writedata = ^writedata[31:WIDTH];
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= in_port;
            sync2_q <= sync1_q;
        end
    end

    // Each bit only follows sync2 after DEBOUNCE_CYCLES consecutive mismatches.
    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_no_db
            assign stable = sync2_q;
        end else begin : g_db
            localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
            localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

            for (genvar i = 0; i < WIDTH; i++) begin : g_bit
                logic [CNT_W-1:0] cnt_q;
                logic             stable_q;

                always_ff @(posedge clk or negedge reset_n) begin
                    if (!reset_n) begin
                        cnt_q    <= '0;
                        stable_q <= 1'b0;
                    end else if (sync2_q[i] == stable_q) begin
                        cnt_q <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        stable_q <= sync2_q[i];
                        cnt_q    <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                assign stable[i] = stable_q;
            end
        end
    endgenerate

    assign rise = stable & ~prev_q;
    assign fall = ~stable & prev_q;

    always_comb begin
        edge_hit = rise | fall;
        if (EDGE_TYPE == 0) begin
            edge_hit = rise;
        end else if (EDGE_TYPE == 1) begin
            edge_hit = fall;
        end
    end

    always_comb begin
        cap_clear  = '0;
        irq_mask_d = irq_mask_q;
        if (wr_en && (address == 2'd3)) begin
            cap_clear = writedata[WIDTH-1:0];
        end
        if (wr_en && (address == 2'd2)) begin
            irq_mask_d = writedata[WIDTH-1:0];
        end
        // A new edge in the same cycle as its clear keeps the bit set.
        edge_capture_d = (edge_capture_q & ~cap_clear) | edge_hit;
    end

    always_comb begin
        readdata_d = '0;
        case (address)
            2'd0:    readdata_d[WIDTH-1:0] = stable;
            2'd2:    readdata_d[WIDTH-1:0] = irq_mask_q;
            2'd3:    readdata_d[WIDTH-1:0] = edge_capture_q;
            default: readdata_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_q         <= '0;
            edge_capture_q <= '0;
            irq_mask_q     <= '0;
            readdata_q     <= '0;
        end else begin
            prev_q         <= stable;
            edge_capture_q <= edge_capture_d;
            irq_mask_q     <= irq_mask_d;
            readdata_q     <= readdata_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = |(edge_capture_q & irq_mask_q);

endmodule
